// File: rtl/steady_detector.sv
// steady_detector: tracks per-round element updates and change activity,
// emits a round-complete pulse and a sticky steady-state flag.
module steady_detector #(
    parameter int NUM_ELEM      = 32,
    parameter int IDX_W         = $clog2(NUM_ELEM),
    parameter int STEADY_ROUNDS = 4,
    parameter int CNT_W         = $clog2(STEADY_ROUNDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             validRule,
    input  logic [IDX_W-1:0] rule_idx,
    input  logic             changed,
    input  logic             clr_updated,
    output logic             is_steady_state,
    output logic             steady,
    output logic [CNT_W-1:0] round_cnt,
    output logic [15:0]      rounds_total
);

    localparam logic [IDX_W:0]    NUM_L  = NUM_ELEM[IDX_W:0];
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STEADY_ROUNDS);
    localparam logic [NUM_ELEM-1:0] ONE  = {{(NUM_ELEM-1){1'b0}}, 1'b1};

    logic [NUM_ELEM-1:0] mask_q, mask_d;
    logic [NUM_ELEM-1:0] hit, full;
    logic                dirty_q, dirty_d;
    logic                dirty_any;
    logic                rule_ok;
    logic                done;
    logic                pulse_q;
    logic                steady_q, steady_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         total_q, total_d;

    // Out-of-range indices are dropped; clr_updated wipes the round
    // before this cycle's rule lands, so a coincident rule is kept.
    always_comb begin
        rule_ok   = validRule && ({1'b0, rule_idx} < NUM_L);
        hit       = rule_ok ? (ONE << rule_idx) : '0;
        full      = (clr_updated ? '0 : mask_q) | hit;
        done      = &full;
        dirty_any = (clr_updated ? 1'b0 : dirty_q) | (rule_ok & changed);
    end

    // Next-state for round tracking, unchanged-round counter and totals.
    always_comb begin
        mask_d   = done ? '0 : full;
        dirty_d  = done ? 1'b0 : dirty_any;
        cnt_d    = cnt_q;
        total_d  = total_q;
        steady_d = steady_q;
        if (done) begin
            if (dirty_any) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (total_q != 16'hFFFF) begin
                total_d = total_q + 16'd1;
            end
            if (cnt_d == CNT_MAX) begin
                steady_d = 1'b1;
            end
        end
    end

    // State registers; rst and clear both restart the detector.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mask_q   <= '0;
            dirty_q  <= 1'b0;
            pulse_q  <= 1'b0;
            steady_q <= 1'b0;
            cnt_q    <= '0;
            total_q  <= '0;
        end else begin
            mask_q   <= mask_d;
            dirty_q  <= dirty_d;
            pulse_q  <= done;
            steady_q <= steady_d;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
        end
    end

    assign is_steady_state = pulse_q;
    assign steady          = steady_q;
    assign round_cnt       = cnt_q;
    assign rounds_total    = total_q;

endmodule

// File: tb/tb_steady_detector.sv
// tb_steady_detector: scoreboard bench for steady_detector,
// two instances (4 and 6 elements) checked every cycle.
module tb_steady_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, clr_a = 1'b0, v_a = 1'b0, ch_a = 1'b0, cu_a = 1'b0;
    logic [1:0] idx_a = '0;
    logic       pls_a, st_a;
    logic [1:0] cnt_a;
    logic [15:0] tot_a;

    logic       rst_b = 1'b1, clr_b = 1'b0, v_b = 1'b0, ch_b = 1'b0, cu_b = 1'b0;
    logic [2:0] idx_b = '0;
    logic       pls_b, st_b;
    logic [1:0] cnt_b;
    logic [15:0] tot_b;

    steady_detector #(.NUM_ELEM(4), .STEADY_ROUNDS(2)) dut_a (
        .clk(clk), .rst(rst_a), .clear(clr_a), .validRule(v_a),
        .rule_idx(idx_a), .changed(ch_a), .clr_updated(cu_a),
        .is_steady_state(pls_a), .steady(st_a),
        .round_cnt(cnt_a), .rounds_total(tot_a)
    );

    steady_detector #(.NUM_ELEM(6), .STEADY_ROUNDS(2)) dut_b (
        .clk(clk), .rst(rst_b), .clear(clr_b), .validRule(v_b),
        .rule_idx(idx_b), .changed(ch_b), .clr_updated(cu_b),
        .is_steady_state(pls_b), .steady(st_b),
        .round_cnt(cnt_b), .rounds_total(tot_b)
    );

    typedef struct {
        logic [7:0] mask;
        logic       dirty;
        int         cnt;
        logic       steady;
        int         total;
        logic       pulse;
    } st_t;

    typedef struct {
        int   inst;
        logic pulse;
        logic steady;
        int   cnt;
        int   total;
    } exp_t;

    st_t  sa, sb;
    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic st_t mstep(st_t s, int n, int r, logic rs,
                                  logic v, int idx, logic c, logic cl);
        st_t        o;
        logic [7:0] full, allm;
        logic       ok, done, dany;
        o = s;
        if (rs) begin
            o.mask = '0; o.dirty = 0; o.cnt = 0;
            o.steady = 0; o.total = 0; o.pulse = 0;
            return o;
        end
        allm = 8'((1 << n) - 1);
        ok   = v && (idx < n);
        full = cl ? 8'h00 : s.mask;
        if (ok) full[idx] = 1'b1;
        done = (full == allm);
        dany = (cl ? 1'b0 : s.dirty) | (ok & c);
        o.pulse = done;
        if (done) begin
            o.mask  = '0;
            o.dirty = 1'b0;
            o.cnt   = dany ? 0 : ((s.cnt < r) ? s.cnt + 1 : r);
            if (o.cnt == r) o.steady = 1'b1;
            if (s.total < 65535) o.total = s.total + 1;
        end else begin
            o.mask  = full;
            o.dirty = dany;
        end
        return o;
    endfunction

    task automatic tick();
        exp_t e;
        sa = mstep(sa, 4, 2, rst_a | clr_a, v_a, int'(idx_a), ch_a, cu_a);
        sb = mstep(sb, 6, 2, rst_b | clr_b, v_b, int'(idx_b), ch_b, cu_b);
        e = '{inst: 0, pulse: sa.pulse, steady: sa.steady,
              cnt: sa.cnt, total: sa.total};
        sbq.push_back(e);
        e = '{inst: 1, pulse: sb.pulse, steady: sb.steady,
              cnt: sb.cnt, total: sb.total};
        sbq.push_back(e);
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.inst == 0) begin
                chk("a.pulse",  int'(pls_a), int'(e.pulse));
                chk("a.steady", int'(st_a),  int'(e.steady));
                chk("a.cnt",    int'(cnt_a), e.cnt);
                chk("a.total",  int'(tot_a), e.total);
            end else begin
                chk("b.pulse",  int'(pls_b), int'(e.pulse));
                chk("b.steady", int'(st_b),  int'(e.steady));
                chk("b.cnt",    int'(cnt_b), e.cnt);
                chk("b.total",  int'(tot_b), e.total);
            end
        end
    endtask

    task automatic rule_a(input int idx, input logic c, input logic cu);
        v_a = 1'b1; idx_a = 2'(idx); ch_a = c; cu_a = cu;
        tick();
        v_a = 1'b0; ch_a = 1'b0; cu_a = 1'b0;
    endtask

    task automatic rule_b(input int idx, input logic c);
        v_b = 1'b1; idx_b = 3'(idx); ch_b = c;
        tick();
        v_b = 1'b0; ch_b = 1'b0;
    endtask

    task automatic round_a(input logic c);
        for (int i = 0; i < 4; i++) rule_a(i, c, 1'b0);
    endtask

    initial begin
        sa = '{mask: 0, dirty: 0, cnt: 0, steady: 0, total: 0, pulse: 0};
        sb = sa;
        #1;
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // first round with changes
        round_a(1'b1);
        tick();
        chk("t1.total", int'(tot_a), 1);

        // two quiet rounds reach steady
        for (int i = 3; i >= 0; i--) rule_a(i, 1'b0, 1'b0);
        tick();
        rule_a(0, 1'b0, 1'b0);
        round_a(1'b0);
        tick();
        chk("t2.steady", int'(st_a), 1);

        // dirty round keeps steady, clear drops all
        rule_a(2, 1'b1, 1'b0);
        rule_a(0, 1'b0, 1'b0);
        rule_a(1, 1'b0, 1'b0);
        rule_a(3, 1'b0, 1'b0);
        tick();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;

        // clr_updated with rule 3 restarts the round at that rule
        rule_a(0, 1'b0, 1'b0);
        rule_a(1, 1'b0, 1'b0);
        rule_a(2, 1'b0, 1'b0);
        rule_a(3, 1'b0, 1'b1);
        tick();
        rule_a(0, 1'b0, 1'b0);
        rule_a(1, 1'b0, 1'b0);
        rule_a(2, 1'b0, 1'b0);
        // controller echo of the pulse must keep this cycle's rule
        rule_a(0, 1'b1, 1'b1);
        rule_a(1, 1'b0, 1'b0);
        rule_a(2, 1'b0, 1'b0);
        rule_a(3, 1'b0, 1'b0);
        tick();

        // reset mid-round with a completing rule
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        round_a(1'b0);
        rule_a(0, 1'b0, 1'b0);
        rule_a(1, 1'b0, 1'b0);
        rule_a(2, 1'b0, 1'b0);
        rst_a = 1'b1;
        rule_a(3, 1'b0, 1'b0);
        rst_a = 1'b0;
        tick();
        chk("t6.total", int'(tot_a), 0);

        // saturation of rounds_total
        force dut_a.total_q = 16'hFFFD;
        sa.total = 65533;
        tick();
        release dut_a.total_q;
        for (int i = 0; i < 3; i++) round_a(1'b0);
        tick();
        chk("t6.sat", int'(tot_a), 65535);

        // out-of-range index on the 6-element instance
        for (int i = 0; i < 5; i++) rule_b(i, 1'b0);
        rule_b(7, 1'b1);
        rule_b(6, 1'b1);
        tick();
        rule_b(5, 1'b0);
        tick();
        chk("t5.cnt", int'(cnt_b), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/steady_detector.md
Name: steady_detector

Overview:
- Observes rule applications from the simulation datapath.
- Tracks which network elements have been updated in the current round, and whether any update changed an element value.
- Produces the round-complete pulse `is_steady_state` and the sticky level `steady` that the simulation control FSM consumes.
- Sits between the datapath's rule-evaluation stage and the control FSM, on the feedback path into the controller.

Parameters:
- NUM_ELEM, 32, number of network elements (rules); must be >= 2.
- IDX_W, $clog2(NUM_ELEM), width of rule index.
- STEADY_ROUNDS, 4, consecutive unchanged complete rounds required to declare steady; must be >= 1.
- CNT_W, $clog2(STEADY_ROUNDS+1), width of the consecutive-round counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous restart at simulation start; same effect as rst.
- validRule  in  1  a rule was applied this cycle.
- rule_idx  in  IDX_W  index of the element updated by the applied rule.
- changed  in  1  applied rule produced a value different from the element's old value; qualified by validRule.
- clr_updated  in  1  controller request to clear the updated mask and dirty flag.
- is_steady_state  out  1  one-cycle pulse: a full round (every element updated at least once) just completed.
- steady  out  1  sticky: STEADY_ROUNDS consecutive rounds completed with no change.
- round_cnt  out  CNT_W  current count of consecutive unchanged rounds; saturates at STEADY_ROUNDS.
- rounds_total  out  16  total completed rounds since reset/clear; saturates at 16'hFFFF.

Behaviour:
- **Reset.** rst or clear (either, same cycle) sets mask=0, dirty=0, is_steady_state=0, steady=0, round_cnt=0, rounds_total=0. Reset dominates all other inputs.
- **Valid rule.** A rule is valid when validRule=1 and rule_idx<NUM_ELEM.
  - Sets mask[rule_idx].
  - If changed=1, sets dirty.
  - Duplicate indices within a round are idempotent for the mask; changed is still ORed into dirty.
- **Invalid rule.** rule_idx>=NUM_ELEM is ignored entirely (no mask bit, no dirty update).
- **Completion test.** done_next = (mask | onehot(valid rule_idx)) == all-ones. It is evaluated combinationally, and registered as is_steady_state one cycle after the completing rule (latency 1).
- **On a completing edge:**
  - mask <= 0, dirty <= 0.
  - If (dirty | this cycle's changed)=0: round_cnt <= min(round_cnt+1, STEADY_ROUNDS). Otherwise round_cnt <= 0.
  - rounds_total increments, saturating.
- **Steady.** steady is set on the edge where round_cnt becomes STEADY_ROUNDS. It is then held (sticky) until rst/clear. Later dirty rounds reset round_cnt but do not clear steady.
- **is_steady_state pulse.** High for exactly one cycle per completed round. Back-to-back rounds are impossible for NUM_ELEM>=2, so pulses are never adjacent.
- **clr_updated.** Clears mask and dirty. A same-cycle valid rule is then applied to the cleared state, so mask <= onehot(rule_idx) and dirty <= changed.
  - clr_updated does not affect round_cnt, steady, rounds_total, or a pending completion.
  - If clr_updated coincides with a completing rule, completion still counts.
- **Controller feedback.** The controller feeds is_steady_state back on clr_updated (combinational in the controller). That redundant clear on the following cycle must not lose a rule arriving in that cycle.
- **No FSM beyond the above.** The state is mask, dirty, round_cnt, steady flag, and rounds counter. All outputs are registered.

Test Plan:
1. NUM_ELEM=4, STEADY_ROUNDS=2. Reset, then rules 0,1,2,3 with changed=1 -> is_steady_state pulses one cycle after rule 3; round_cnt=0, rounds_total=1, steady=0.
2. Follow 1 with two rounds 3,2,1,0 and 0,0,1,2,3, all changed=0 -> round_cnt 1 then 2; steady rises with the second pulse; rounds_total=3.
3. After steady, a round with rule 2 changed=1 -> round_cnt=0, steady remains 1. Assert clear -> all outputs 0 next cycle.
4. Rules 0,1,2, then clr_updated together with rule 3 -> no pulse; mask=4'b1000. Then rules 0,1,2 -> pulse after rule 2.
5. rule_idx=5 with NUM_ELEM=6 vs rule_idx=7 with NUM_ELEM=6 (changed=1) -> index 7 ignored: no mask bit, dirty unchanged; round completes only on valid indices.
6. Drive rst mid-round (mask=4'b0111, round_cnt=1) with simultaneous validRule idx 3 -> next cycle all state 0, no pulse; rounds_total stays 0. Also force 65536 rounds -> rounds_total holds 16'hFFFF.
